// File: rtl/grayscale_pkg.sv
// grayscale_pkg: shared types and constants for the grayscale converter
package grayscale_pkg;
  typedef logic [511:0] t_block;
  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] g;
    logic [7:0] r;
  } t_pixel;
  localparam int NPIX = 16;
  localparam logic [7:0] COEF_R = 8'd77;
  localparam logic [7:0] COEF_G = 8'd150;
  localparam logic [7:0] COEF_B = 8'd29;
  typedef enum logic [1:0] {IDLE, RUN, DONE} t_state;
endpackage

// File: rtl/grayscale_compute_if.sv
// grayscale_compute_if: upstream FIFO and downstream stream signals
interface grayscale_compute_if;
  import grayscale_pkg::*;
  t_block in_data;
  logic   in_not_empty;
  logic   in_deq_en;
  t_block out_data;
  logic   out_valid;
  logic   out_ready;
  modport master (input in_data, in_not_empty, out_ready, output in_deq_en, out_data, out_valid);
  modport slave (output in_data, in_not_empty, out_ready, input in_deq_en, out_data, out_valid);
endinterface

// File: rtl/grayscale_pixel.sv
// grayscale_pixel: 3-stage luma pipeline for one RGBA pixel
module grayscale_pixel
  import grayscale_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   adv,
  input  t_pixel pix_in,
  output t_pixel pix_out
);
  logic [15:0] pr, pg, pb, sum;
  logic [7:0]  a1, a2;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      {pr, pg, pb, a1} <= '0;
      {sum, a2}        <= '0;
      pix_out          <= '0;
    end else if (adv) begin
      pr      <= 16'(pix_in.r) * 16'(COEF_R);
      pg      <= 16'(pix_in.g) * 16'(COEF_G);
      pb      <= 16'(pix_in.b) * 16'(COEF_B);
      a1      <= pix_in.a;
      sum     <= pr + pg + pb;
      a2      <= a1;
      pix_out <= '{a: a2, b: sum[15:8], g: sum[15:8], r: sum[15:8]};
    end
endmodule

// File: rtl/grayscale_compute.sv
// grayscale_compute: job-controlled RGBA-to-gray block converter
module grayscale_compute
  import grayscale_pkg::*;
#(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [CNT_WIDTH-1:0] total_blocks,
  grayscale_compute_if.master  bus,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_WIDTH-1:0] blocks_out
);
  t_state state, state_n;
  logic [CNT_WIDTH-1:0] issued, total;
  logic v1, v2, v3, adv, launch;
  assign adv           = !v3 || bus.out_ready;
  assign launch        = (state != RUN) && start;
  assign bus.out_valid = v3;
  assign bus.in_deq_en = (state == RUN) && bus.in_not_empty && adv && (issued < total);
  assign busy          = (state == RUN);
  assign done          = (state == DONE);
  for (genvar i = 0; i < NPIX; i++) begin : g_pix
    grayscale_pixel u_pix (
      .clk    (clk),
      .reset  (reset),
      .adv    (adv),
      .pix_in (bus.in_data[32*i +: 32]),
      .pix_out(bus.out_data[32*i +: 32])
    );
  end
  always_comb begin
    state_n = state;
    if (launch) state_n = RUN;
    else if (state == RUN && blocks_out == total) state_n = DONE;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state      <= IDLE;
      {v1, v2, v3} <= '0;
      issued     <= '0;
      total      <= '0;
      blocks_out <= '0;
    end else begin
      state <= state_n;
      if (adv) {v1, v2, v3} <= {bus.in_deq_en, v1, v2};
      if (launch) begin
        total      <= total_blocks;
        issued     <= '0;
        blocks_out <= '0;
      end else begin
        if (bus.in_deq_en) issued <= issued + CNT_WIDTH'(1);
        if (v3 && bus.out_ready) blocks_out <= blocks_out + CNT_WIDTH'(1);
      end
    end
endmodule

// File: tb/tb_grayscale_compute.sv
// tb_grayscale_compute: directed checks of the grayscale converter with a FIFO model
module tb_grayscale_compute;
  import grayscale_pkg::*;
  logic        clk = 0;
  logic        reset = 1;
  logic        start = 0;
  logic [31:0] total_blocks = 0;
  logic        busy, done;
  logic [31:0] blocks_out;
  int          errors = 0, checks = 0;
  t_block      mem [64];
  int          rd = 0, wr = 0, deq_cnt = 0, out_n = 0;
  t_block      out_log [64];
  grayscale_compute_if bus ();
  grayscale_compute #(.CNT_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .total_blocks(total_blocks),
    .bus(bus.master), .busy(busy), .done(done), .blocks_out(blocks_out)
  );
  always #5 clk = ~clk;
  assign bus.in_data      = mem[rd];
  assign bus.in_not_empty = (wr != rd);
  always @(posedge clk) if (bus.in_deq_en) rd <= rd + 1;
  always @(negedge clk) begin
    if (bus.in_deq_en) deq_cnt++;
    if (bus.out_valid && bus.out_ready) begin
      out_log[out_n] = bus.out_data;
      out_n++;
    end
  end
  task automatic tick(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic check(string tag, logic [511:0] obs, logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic push(t_block b);
    mem[wr] = b;
    wr++;
  endtask
  task automatic go(int n);
    total_blocks = n;
    start = 1;
    tick(1);
    start = 0;
  endtask
  task automatic wait_done(string tag);
    int k = 0;
    while (!done && k < 300) begin
      tick(1);
      k++;
    end
    check(tag, done, 1);
  endtask
  function automatic t_block mk(int k);
    t_block b;
    for (int i = 0; i < 16; i++)
      b[32*i +: 32] = {8'(8'hA0 ^ k), 8'(3*i + k), 8'(i*17), 8'(k*29 + i)};
    return b;
  endfunction
  function automatic t_block conv(t_block b);
    t_block o;
    int y;
    for (int i = 0; i < 16; i++) begin
      y = (77*int'(b[32*i +: 8]) + 150*int'(b[32*i+8 +: 8]) + 29*int'(b[32*i+16 +: 8])) / 256;
      o[32*i +: 32] = {b[32*i+24 +: 8], 8'(y), 8'(y), 8'(y)};
    end
    return o;
  endfunction
  initial begin
    t_block b2, e2, hold;
    int d0, o0, k;
    bus.out_ready = 1;
    tick(2);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_blocks_out", blocks_out, 0);
    check("rst_deq", bus.in_deq_en, 0);
    reset = 0;
    tick(1);
    // single all-white block, 3-cycle latency
    push({16{32'hFFFFFFFF}});
    go(1);
    check("t1_deq", bus.in_deq_en, 1);
    tick(2);
    check("t1_lat_early", bus.out_valid, 0);
    tick(1);
    check("t1_lat_valid", bus.out_valid, 1);
    check("t1_data", bus.out_data, {16{32'hFFFFFFFF}});
    tick(1);
    check("t1_blocks_out", blocks_out, 1);
    tick(1);
    check("t1_done", done, 1);
    // hand-computed pixels
    b2 = '0;
    e2 = '0;
    b2[31:0] = 32'h00000064;   e2[31:0] = 32'h001E1E1E;
    b2[63:32] = 32'h0000C800;  e2[63:32] = 32'h00757575;
    b2[95:64] = 32'h00320000;  e2[95:64] = 32'h00050505;
    b2[127:96] = 32'h801E140A; e2[127:96] = 32'h80121212;
    push(b2);
    go(1);
    k = 0;
    while (!bus.out_valid && k < 20) begin
      tick(1);
      k++;
    end
    check("t2_data", bus.out_data, e2);
    wait_done("t2_done");
    // backpressure stall
    d0 = deq_cnt;
    o0 = out_n;
    for (int i = 0; i < 8; i++) push(mk(i));
    go(8);
    tick(1);
    bus.out_ready = 0;
    tick(4);
    check("t3_stall_deqs", (deq_cnt - d0) <= 3, 1);
    check("t3_stall_valid", bus.out_valid, 1);
    hold = bus.out_data;
    d0 = deq_cnt - d0;
    tick(4);
    check("t3_hold_data", bus.out_data, hold);
    check("t3_hold_valid", bus.out_valid, 1);
    check("t3_no_out", out_n - o0, 0);
    bus.out_ready = 1;
    d0 = deq_cnt - d0;
    wait_done("t3_done");
    check("t3_deqs", deq_cnt - d0, 8);
    check("t3_outs", out_n - o0, 8);
    check("t3_blocks_out", blocks_out, 8);
    for (int i = 0; i < 8; i++) check($sformatf("t3_out%0d", i), out_log[o0 + i], conv(mk(i)));
    // issue limit with extra FIFO entries
    d0 = deq_cnt;
    for (int i = 0; i < 6; i++) push(mk(20 + i));
    go(4);
    wait_done("t4_done");
    check("t4_deqs", deq_cnt - d0, 4);
    check("t4_left", wr - rd, 2);
    // zero-length job, then a normal one
    d0 = deq_cnt;
    go(0);
    tick(1);
    check("t5_done", done, 1);
    check("t5_no_deq", deq_cnt - d0, 0);
    go(2);
    check("t5_busy", busy, 1);
    wait_done("t5b_done");
    check("t5b_deqs", deq_cnt - d0, 2);
    check("t5b_blocks_out", blocks_out, 2);
    check("t5b_empty", wr - rd, 0);
    // reset mid-job
    for (int i = 0; i < 5; i++) push(mk(40 + i));
    d0 = deq_cnt;
    o0 = out_n;
    go(5);
    k = 0;
    while ((deq_cnt - d0) < 2 && k < 20) begin
      tick(1);
      k++;
    end
    reset = 1;
    #1;
    check("t6_out_valid", bus.out_valid, 0);
    check("t6_blocks_out", blocks_out, 0);
    check("t6_busy", busy, 0);
    check("t6_done", done, 0);
    check("t6_deq", bus.in_deq_en, 0);
    tick(1);
    reset = 0;
    tick(5);
    check("t6_deqs", deq_cnt - d0, 2);
    check("t6_no_out", out_n - o0, 0);
    check("t6_idle", busy, 0);
    go(3);
    wait_done("t6b_done");
    check("t6b_blocks_out", blocks_out, 3);
    check("t6b_deqs", deq_cnt - d0, 5);
    check("t6b_out", out_log[out_n - 1], conv(mk(44)));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/grayscale_compute.md
GRAYSCALE_COMPUTE -- requirements
Module: grayscale_compute

Interface
REQ-001 SHALL have parameter CNT_WIDTH, default 32: width of the block-count configuration and the internal counters.
REQ-002 SHALL have port clk, input, 1: the single clock for all state.
REQ-003 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-004 SHALL have port start, input, 1: one-cycle pulse that begins a job.
REQ-005 SHALL have port total_blocks, input, CNT_WIDTH: number of 512-bit blocks in the job, sampled when start is accepted.
REQ-006 SHALL have port in_data, input, 512: head entry of the upstream FIFO, valid the same cycle.
REQ-007 SHALL have port in_not_empty, input, 1: the upstream FIFO holds at least one block.
REQ-008 SHALL have port in_deq_en, output, 1: pops the upstream FIFO head this cycle.
REQ-009 SHALL have port out_data, output, 512: converted block.
REQ-010 SHALL have port out_valid, output, 1: out_data is valid.
REQ-011 SHALL have port out_ready, input, 1: the downstream stage accepts out_data this cycle.
REQ-012 SHALL have port busy, output, 1: high in RUN.
REQ-013 SHALL have port done, output, 1: high in DONE.
REQ-014 SHALL have port blocks_out, output, CNT_WIDTH: count of blocks accepted downstream in the current job.

Function
REQ-015 SHALL treat a block as 16 pixels of 32 bits each; pixel i occupies bits [32i+31:32i], with byte0 = R, byte1 = G, byte2 = B and byte3 = A.
REQ-016 SHALL compute Y = (77*R + 150*G + 29*B) >> 8 as unsigned; products are 16-bit, the sum is 16-bit with no overflow possible (maximum 65280), and Y is sum[15:8].
REQ-017 SHALL output each pixel as {A, Y, Y, Y}, keeping the same pixel position.
REQ-018 SHALL use a 3-stage pipeline: S1 registers the products and A; S2 registers the sum; S3 registers the packed pixel. out_valid is the S3 valid bit.
REQ-019 SHALL advance the whole pipeline when adv = !out_valid || out_ready; when adv is low, all stages hold.
REQ-020 SHALL produce out_data exactly 3 cycles after an in_deq_en cycle when out_ready is held high.
REQ-021 SHALL drive in_deq_en = (state==RUN) && in_not_empty && adv && (issued < total).
REQ-022 SHALL never drive in_deq_en when in_not_empty is low.
REQ-023 SHALL increment issued on in_deq_en.
REQ-024 SHALL increment blocks_out on out_valid && out_ready.
REQ-025 SHALL implement an FSM with states IDLE, RUN and DONE.
REQ-026 SHALL move from IDLE or DONE to RUN on start: latch total_blocks; clear issued, blocks_out and done.
REQ-027 SHALL, on start with total_blocks == 0, go to DONE on the next cycle and issue no dequeues.
REQ-028 SHALL move from RUN to DONE on the cycle after blocks_out reaches total.
REQ-029 SHALL remain in DONE until the next start.
REQ-030 SHALL ignore start while in RUN.
REQ-031 SHALL stop issuing when issued == total, even if the FIFO is not empty.
REQ-032 SHALL, with out_ready low and S3 full, hold out_data and out_valid stable and drop no data.

Reset
REQ-033 SHALL, on reset, set state to IDLE, clear all valid bits and data registers, and set issued, total, blocks_out, busy, done, out_valid and in_deq_en to 0.
REQ-034 SHALL, on reset mid-job, discard all in-flight blocks with no output, and restart only on a new start.

Structure
REQ-035 SHALL take t_block (512-bit), t_pixel (packed struct {a, b, g, r}), the constants COEF_R=77, COEF_G=150 and COEF_B=29, and the state enum from grayscale_pkg.
REQ-036 SHALL implement the per-pixel 3-stage datapath as sub-module grayscale_pixel (ports clk, reset, adv, pix_in, pix_out), instantiated 16 times.
REQ-037 SHALL keep the valid bits, counters and FSM in grayscale_compute.

Verification
REQ-038 SHALL cover: total=1, all pixels 0xFFFFFFFF, out_ready=1 -> out_data all 0xFFFFFFFF at 3 cycles after in_deq_en, then done=1 and blocks_out=1.
REQ-039 SHALL cover: pixels R=100 (0x00000064), G=200 (0x0000C800), B=50 (0x00320000) and RGB=10,20,30 with A=0x80 (0x801E140A) -> 0x001E1E1E, 0x00757575, 0x00050505 and 0x80121212.
REQ-040 SHALL cover: total=8, FIFO preloaded with 8 blocks, out_ready=0 for cycles 2-10 -> at most 3 dequeues before the stall, out_data stable while stalled, all 8 outputs in order, and exactly 8 dequeues.
REQ-041 SHALL cover: total=4, FIFO holding 6 blocks -> exactly 4 in_deq_en pulses, 2 blocks left in the FIFO, then done.
REQ-042 SHALL cover: total=0 then start -> DONE next cycle and no in_deq_en; a second start with total=2 then completes normally.
REQ-043 SHALL cover: reset asserted after 2 of 5 blocks have been issued -> out_valid=0, counters=0, state=IDLE, and no further dequeues until start.
